// File: rtl/mips_pkg.sv
// Shared MIPS ISA constants: opcodes, function codes and instruction field positions.
package mips_pkg;

  localparam int IMM_W = 16;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = 6;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int REG_FLD_W  = 5;
  localparam int SHAMT_LSB  = 6;
  localparam int SHAMT_W    = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int FUNCT_W    = 6;
  localparam int IMM_LSB    = 0;
  localparam int ADDR_LSB   = 0;
  localparam int ADDR_W     = 26;

endpackage

// File: rtl/id_stage_pipe_reg_file.sv
// Two-read, one-write register file with R0 tied to zero and optional
// same-cycle write-to-read forwarding.
module reg_file #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic [1:0][AW-1:0]   raddr;
  logic [1:0][XLEN-1:0] rdata;

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign raddr = {raddr2, raddr1};

  // Entry 0 is never written, but the read mux also masks it so R0 is zero
  // even before the first reset.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rport
      logic bypass_hit;
      assign bypass_hit = (BYPASS != 0) && we && (waddr == raddr[gi]);
      assign rdata[gi]  = (raddr[gi] == '0) ? '0 :
                          bypass_hit        ? wdata : regs_q[raddr[gi]];
    end
  endgenerate

  assign rdata1 = rdata[0];
  assign rdata2 = rdata[1];

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage: register read, field decode, immediate
// extension and destination select, registered into a handshaked ID/EX stage.
module id_stage_pipe
  import mips_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction32,
  input  logic              reg_dst,
  input  logic              zero_ext,
  input  logic              flush,
  input  logic              wb_write,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   read_data1,
  output logic [XLEN-1:0]   read_data2,
  output logic [XLEN-1:0]   extended_imm,
  output logic [REG_AW-1:0] dest_reg,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [4:0]        shamt,
  output logic [25:0]       address
);

  logic [REG_FLD_W-1:0] rs_field, rt_field, rd_field;
  logic [REG_AW-1:0]    rs_addr, rt_addr, rd_addr;
  logic [IMM_W-1:0]     imm;
  logic [XLEN-1:0]      rdata1, rdata2, ext_imm;
  logic                 accept;

  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   read_data1_q, read_data1_d;
  logic [XLEN-1:0]   read_data2_q, read_data2_d;
  logic [XLEN-1:0]   extended_imm_q, extended_imm_d;
  logic [REG_AW-1:0] dest_reg_q, dest_reg_d;
  logic [5:0]        opcode_q, opcode_d;
  logic [5:0]        funct_q, funct_d;
  logic [4:0]        shamt_q, shamt_d;
  logic [25:0]       address_q, address_d;

  assign rs_field = instruction32[RS_LSB +: REG_FLD_W];
  assign rt_field = instruction32[RT_LSB +: REG_FLD_W];
  assign rd_field = instruction32[RD_LSB +: REG_FLD_W];
  // Smaller register files alias the upper register numbers onto the low ones.
  assign rs_addr  = rs_field[REG_AW-1:0];
  assign rt_addr  = rt_field[REG_AW-1:0];
  assign rd_addr  = rd_field[REG_AW-1:0];
  assign imm      = instruction32[IMM_LSB +: IMM_W];

  generate
    if (XLEN > IMM_W) begin : g_ext
      assign ext_imm = zero_ext ? {{(XLEN-IMM_W){1'b0}}, imm}
                                : {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    end else begin : g_no_ext
      assign ext_imm = imm;
    end
  endgenerate

  reg_file #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .BYPASS   (BYPASS)
  ) u_reg_file (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_write),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (rs_addr),
    .raddr2 (rt_addr),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d    = out_valid_q;
    read_data1_d   = read_data1_q;
    read_data2_d   = read_data2_q;
    extended_imm_d = extended_imm_q;
    dest_reg_d     = dest_reg_q;
    opcode_d       = opcode_q;
    funct_d        = funct_q;
    shamt_d        = shamt_q;
    address_d      = address_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d    = 1'b1;
      read_data1_d   = rdata1;
      read_data2_d   = rdata2;
      extended_imm_d = ext_imm;
      dest_reg_d     = reg_dst ? rd_addr : rt_addr;
      opcode_d       = instruction32[OPCODE_LSB +: OPCODE_W];
      funct_d        = instruction32[FUNCT_LSB +: FUNCT_W];
      shamt_d        = instruction32[SHAMT_LSB +: SHAMT_W];
      address_d      = instruction32[ADDR_LSB +: ADDR_W];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      read_data1_q   <= '0;
      read_data2_q   <= '0;
      extended_imm_q <= '0;
      dest_reg_q     <= '0;
      opcode_q       <= '0;
      funct_q        <= '0;
      shamt_q        <= '0;
      address_q      <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      read_data1_q   <= read_data1_d;
      read_data2_q   <= read_data2_d;
      extended_imm_q <= extended_imm_d;
      dest_reg_q     <= dest_reg_d;
      opcode_q       <= opcode_d;
      funct_q        <= funct_d;
      shamt_q        <= shamt_d;
      address_q      <= address_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign read_data1   = read_data1_q;
  assign read_data2   = read_data2_q;
  assign extended_imm = extended_imm_q;
  assign dest_reg     = dest_reg_q;
  assign opcode       = opcode_q;
  assign funct        = funct_q;
  assign shamt        = shamt_q;
  assign address      = address_q;

endmodule
